// File: rtl/mem_pipe_stage.sv
// Memory stage of the in-order pipeline: holds one instruction, waits for its data
// response, aligns load data and discards responses that belong to flushed requests.
module mem_pipe_stage #(
    parameter int DCNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_to_mem_valid,
    output logic        mem_allowin,
    input  logic        ex_rf_we,
    input  logic [4:0]  ex_rf_waddr,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_result,
    input  logic [4:0]  ex_ld_op,
    input  logic        ex_mem_wait,
    input  logic        ex_res_from_mul,
    input  logic        ex_mul_h,
    input  logic        ex_excep,
    input  logic [63:0] mul_result,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        mem_flush,
    input  logic        wb_allowin,
    output logic        mem_to_wb_valid,
    output logic        mem_wb_rf_we,
    output logic [4:0]  mem_wb_waddr,
    output logic [31:0] mem_wb_pc,
    output logic [31:0] mem_wb_result,
    output logic        mem_wb_excep,
    output logic        mem_fwd_we,
    output logic        mem_fwd_busy,
    output logic [4:0]  mem_fwd_waddr,
    output logic [31:0] mem_fwd_data,
    output logic        mem_to_ex_excep
);

    localparam logic [DCNT_W-1:0] DCNT_MAX = {DCNT_W{1'b1}};
    localparam logic [DCNT_W-1:0] DCNT_ONE = DCNT_W'(1'b1);

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  ld_op;
        logic        mem_wait;
        logic        res_from_mul;
        logic        mul_h;
        logic        excep;
    } payload_t;

    payload_t          pay_q, pay_d, ex_pay_s;
    logic              mem_valid_q, mem_valid_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              data_ok_buf_q, data_ok_buf_d;
    logic [31:0]       rdata_buf_q, rdata_buf_d;

    logic        dcnt_zero_s, ready_go_s, allowin_s, to_wb_s;
    logic        accept_s, advance_s, data_take_s, discard_s, orphan_s;
    logic [31:0] lw_s, byte_s, half_s, ld_val_s, result_s;

    // Handshake and response bookkeeping decisions for this cycle.
    always_comb begin
        dcnt_zero_s = (dcnt_q == '0);
        ready_go_s  = ~pay_q.mem_wait | data_ok_buf_q | (data_sram_data_ok & dcnt_zero_s);
        allowin_s   = (~mem_valid_q | (ready_go_s & wb_allowin) | mem_flush) & (dcnt_q != DCNT_MAX);
        to_wb_s     = mem_valid_q & ready_go_s & ~mem_flush;
        accept_s    = ex_to_mem_valid & allowin_s;
        advance_s   = to_wb_s & wb_allowin;
        data_take_s = data_sram_data_ok & dcnt_zero_s & mem_valid_q & pay_q.mem_wait;
        discard_s   = data_sram_data_ok & ~dcnt_zero_s;
        // A flushed request whose response is still in flight becomes an orphan to discard later.
        orphan_s    = mem_flush & mem_valid_q & pay_q.mem_wait & ~data_ok_buf_q & ~data_take_s;
    end

    // Next-state for valid, discard counter, response buffer and payload.
    always_comb begin
        ex_pay_s = '{rf_we: ex_rf_we, waddr: ex_rf_waddr, pc: ex_pc, result: ex_result,
                     ld_op: ex_ld_op, mem_wait: ex_mem_wait, res_from_mul: ex_res_from_mul,
                     mul_h: ex_mul_h, excep: ex_excep};
        pay_d         = pay_q;
        mem_valid_d   = mem_valid_q;
        dcnt_d        = dcnt_q;
        data_ok_buf_d = data_ok_buf_q;
        rdata_buf_d   = rdata_buf_q;

        if (accept_s) begin
            pay_d = ex_pay_s;
        end else begin
            pay_d = pay_q;
        end

        if (allowin_s) begin
            mem_valid_d = ex_to_mem_valid;
        end else begin
            mem_valid_d = mem_valid_q;
        end

        if (orphan_s && !discard_s) begin
            dcnt_d = dcnt_q + DCNT_ONE;
        end else if (discard_s && !orphan_s) begin
            dcnt_d = dcnt_q - DCNT_ONE;
        end else begin
            dcnt_d = dcnt_q;
        end

        if (accept_s || mem_flush) begin
            data_ok_buf_d = 1'b0;
        end else if (data_take_s && !advance_s) begin
            data_ok_buf_d = 1'b1;
            rdata_buf_d   = data_sram_rdata;
        end else begin
            data_ok_buf_d = data_ok_buf_q;
        end
    end

    // Control state: cleared asynchronously so a reset drops any pending load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid_q   <= 1'b0;
            dcnt_q        <= '0;
            data_ok_buf_q <= 1'b0;
        end else begin
            mem_valid_q   <= mem_valid_d;
            dcnt_q        <= dcnt_d;
            data_ok_buf_q <= data_ok_buf_d;
        end
    end

    // Datapath registers; only meaningful while mem_valid_q is set.
    always_ff @(posedge clk) begin
        pay_q       <= pay_d;
        rdata_buf_q <= rdata_buf_d;
    end

    // Load alignment and result selection.
    always_comb begin
        lw_s = data_ok_buf_q ? rdata_buf_q : data_sram_rdata;
        case (pay_q.result[1:0])
            2'd0:    byte_s = {24'd0, lw_s[7:0]};
            2'd1:    byte_s = {24'd0, lw_s[15:8]};
            2'd2:    byte_s = {24'd0, lw_s[23:16]};
            2'd3:    byte_s = {24'd0, lw_s[31:24]};
            default: byte_s = 32'd0;
        endcase
        half_s = pay_q.result[1] ? {16'd0, lw_s[31:16]} : {16'd0, lw_s[15:0]};

        if (pay_q.ld_op[4]) begin
            ld_val_s = {{24{byte_s[7]}}, byte_s[7:0]};
        end else if (pay_q.ld_op[3]) begin
            ld_val_s = byte_s;
        end else if (pay_q.ld_op[2]) begin
            ld_val_s = {{16{half_s[15]}}, half_s[15:0]};
        end else if (pay_q.ld_op[1]) begin
            ld_val_s = half_s;
        end else begin
            ld_val_s = lw_s;
        end

        if (pay_q.ld_op != 5'd0) begin
            result_s = ld_val_s;
        end else if (pay_q.res_from_mul && pay_q.mul_h) begin
            result_s = mul_result[63:32];
        end else if (pay_q.res_from_mul) begin
            result_s = mul_result[31:0];
        end else begin
            result_s = pay_q.result;
        end
    end

    // Output drive.
    always_comb begin
        mem_allowin     = allowin_s;
        mem_to_wb_valid = to_wb_s;
        mem_wb_rf_we    = pay_q.rf_we & ~pay_q.excep;
        mem_wb_waddr    = pay_q.waddr;
        mem_wb_pc       = pay_q.pc;
        mem_wb_result   = result_s;
        mem_wb_excep    = pay_q.excep;
        mem_fwd_we      = mem_valid_q & pay_q.rf_we;
        mem_fwd_busy    = mem_valid_q & (pay_q.ld_op != 5'd0) & ~ready_go_s;
        mem_fwd_waddr   = pay_q.waddr;
        mem_fwd_data    = result_s;
        mem_to_ex_excep = mem_valid_q & pay_q.excep;
    end

endmodule
